// File: rtl/gpio_irq_pkg.sv
// Shared register-map constants and address-window helper for the gpio_irq peripheral.
package gpio_irq_pkg;

    localparam int WINDOW_SIZE = 8;

    localparam logic [2:0] OFF_OUT    = 3'd0;
    localparam logic [2:0] OFF_TRIS   = 3'd1;
    localparam logic [2:0] OFF_IN     = 3'd2;
    localparam logic [2:0] OFF_OUTSET = 3'd3;
    localparam logic [2:0] OFF_OUTCLR = 3'd4;
    localparam logic [2:0] OFF_IE     = 3'd5;
    localparam logic [2:0] OFF_EDGE   = 3'd6;
    localparam logic [2:0] OFF_IFLAG  = 3'd7;

    // Modular subtraction keeps the test correct even when the window sits near 8'hFF.
    function automatic logic inWindow(input logic [7:0] addr, input logic [7:0] base);
        logic [7:0] diff;
        diff = addr - base;
        return (diff < 8'(WINDOW_SIZE));
    endfunction

endpackage

// File: rtl/gpio_irq_if.sv
// TRSQ8 CPU data-bus bundle as seen by the gpio_irq register window.
interface gpio_irq_if;
    import gpio_irq_pkg::*;

    logic [7:0] addr;
    logic [7:0] dout;
    logic [7:0] din;
    logic       wr_en;
    logic       rd_en;

    modport master (output addr, output dout, output wr_en, output rd_en, input din);
    modport slave  (input addr, input dout, input wr_en, input rd_en, output din);

endinterface

// File: rtl/gpio_irq_sync.sv
// Multi-stage pad synchroniser with a one-cycle history flop and rise/fall detection.
module gpio_sync
    import gpio_irq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] in_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
    logic [WIDTH-1:0]                  prev_q;

    // Stage 0 takes the raw pad; the last stage is the architectural IN value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
            prev_q  <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], pin_i};
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign in_o   = chain_q[SYNC_STAGES-1];
    assign rise_o = in_o & ~prev_q;
    assign fall_o = ~in_o & prev_q;

endmodule

// File: rtl/gpio_irq.sv
// GPIO peripheral: register window, atomic set/clear, edge-triggered flags and a level irq.
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR   = 8'h80,
    parameter int         WIDTH       = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    gpio_irq_if.slave        bus,
    input  logic [WIDTH-1:0] port_in,
    output logic [WIDTH-1:0] port_out,
    output logic [WIDTH-1:0] port_tris,
    output logic             irq
);

    localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

    logic [2:0]       regOff;
    logic             inWin;
    logic             wrHit;
    logic             rdHit;
    logic [WIDTH-1:0] wdata;

    logic [WIDTH-1:0] outReg_q,  outReg_d;
    logic [WIDTH-1:0] trisReg_q, trisReg_d;
    logic [WIDTH-1:0] ieReg_q,   ieReg_d;
    logic [WIDTH-1:0] edgeReg_q, edgeReg_d;
    logic [WIDTH-1:0] iflag_q,   iflag_d;
    logic [7:0]       rdData_q,  rdData_d;
    logic [2:0]       armCnt_q,  armCnt_d;
    logic [7:0]       rdMux;

    logic [WIDTH-1:0] syncIn;
    logic [WIDTH-1:0] riseDet;
    logic [WIDTH-1:0] fallDet;
    logic [WIDTH-1:0] events;
    logic             arm;

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pin_i   (port_in),
        .in_o    (syncIn),
        .rise_o  (riseDet),
        .fall_o  (fallDet)
    );

    assign regOff = bus.addr[2:0] - BASE_ADDR[2:0];
    assign inWin  = inWindow(bus.addr, BASE_ADDR);
    assign wrHit  = bus.wr_en & inWin;
    assign rdHit  = bus.rd_en & inWin & ~bus.wr_en;
    assign wdata  = bus.dout[WIDTH-1:0];

    // Flags stay quiet until the synchroniser has flushed its post-reset zeros.
    assign arm    = (armCnt_q == ARM_CYCLES);
    assign events = trisReg_q & ((edgeReg_q & fallDet) | (~edgeReg_q & riseDet)) & {WIDTH{arm}};

    always_comb begin
        outReg_d  = outReg_q;
        trisReg_d = trisReg_q;
        ieReg_d   = ieReg_q;
        edgeReg_d = edgeReg_q;
        iflag_d   = iflag_q;
        if (wrHit) begin
            case (regOff)
                OFF_OUT:    outReg_d  = wdata;
                OFF_TRIS:   trisReg_d = wdata;
                OFF_OUTSET: outReg_d  = outReg_q | wdata;
                OFF_OUTCLR: outReg_d  = outReg_q & ~wdata;
                OFF_IE:     ieReg_d   = wdata;
                OFF_EDGE:   edgeReg_d = wdata;
                OFF_IFLAG:  iflag_d   = iflag_q & ~wdata;
                default:    ;
            endcase
        end
        // A coincident event overrides the W1C of the same bit.
        iflag_d  = iflag_d | events;
        armCnt_d = arm ? armCnt_q : armCnt_q + 3'd1;
    end

    always_comb begin
        rdMux = '0;
        case (regOff)
            OFF_OUT:   rdMux[WIDTH-1:0] = outReg_q;
            OFF_TRIS:  rdMux[WIDTH-1:0] = trisReg_q;
            OFF_IN:    rdMux[WIDTH-1:0] = syncIn;
            OFF_IE:    rdMux[WIDTH-1:0] = ieReg_q;
            OFF_EDGE:  rdMux[WIDTH-1:0] = edgeReg_q;
            OFF_IFLAG: rdMux[WIDTH-1:0] = iflag_q;
            default:   rdMux = '0;
        endcase
        rdData_d = rdHit ? rdMux : rdData_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outReg_q  <= '0;
            trisReg_q <= '1;
            ieReg_q   <= '0;
            edgeReg_q <= '0;
            iflag_q   <= '0;
            rdData_q  <= '0;
            armCnt_q  <= '0;
        end else begin
            outReg_q  <= outReg_d;
            trisReg_q <= trisReg_d;
            ieReg_q   <= ieReg_d;
            edgeReg_q <= edgeReg_d;
            iflag_q   <= iflag_d;
            rdData_q  <= rdData_d;
            armCnt_q  <= armCnt_d;
        end
    end

    assign bus.din   = inWin ? rdData_q : 8'hzz;
    assign port_out  = outReg_q;
    assign port_tris = trisReg_q;
    assign irq       = |(iflag_q & ieReg_q);

endmodule

// File: tb/tb_gpio_irq.sv
// Self-checking bench for gpio_irq: directed scenarios plus randomized traffic against a pin-history model.
module tb_gpio_irq;

    localparam logic [7:0] BASE = 8'h80;
    localparam int         S    = 2;

    logic       clk;
    logic       reset_n;
    logic [7:0] port_in;
    logic [7:0] port_out;
    logic [7:0] port_tris;
    logic       irq;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] mOut, mTris, mIe, mEdge, mIflag, mRd;
    logic [7:0] hist[$];
    int         cyc;
    logic [7:0] curPins;

    gpio_irq_if bus ();

    gpio_irq #(
        .BASE_ADDR   (BASE),
        .WIDTH       (8),
        .SYNC_STAGES (S)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .port_in   (port_in),
        .port_out  (port_out),
        .port_tris (port_tris),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    // One bus/pin cycle: the model sees the pre-edge inputs, then the clock edge is taken.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] a,
                                 input logic [7:0] d, input logic [7:0] pins);
        logic [7:0] off, cur, prv, ev, rv;
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.addr  = a;
        bus.dout  = d;
        port_in   = pins;
        curPins   = pins;
        off = a - BASE;
        cur = hist[S-1];
        prv = hist[S];
        ev  = 8'h00;
        if (cyc >= S + 1) begin
            for (int i = 0; i < 8; i++) begin
                if (mTris[i]) ev[i] = mEdge[i] ? (prv[i] & ~cur[i]) : (cur[i] & ~prv[i]);
            end
        end
        if (rd && !wr && off < 8) begin
            case (off)
                8'd0:    rv = mOut;
                8'd1:    rv = mTris;
                8'd2:    rv = cur;
                8'd5:    rv = mIe;
                8'd6:    rv = mEdge;
                8'd7:    rv = mIflag;
                default: rv = 8'h00;
            endcase
            mRd = rv;
        end
        if (wr && off < 8) begin
            case (off)
                8'd0:    mOut   = d;
                8'd1:    mTris  = d;
                8'd3:    mOut   = mOut | d;
                8'd4:    mOut   = mOut & ~d;
                8'd5:    mIe    = d;
                8'd6:    mEdge  = d;
                8'd7:    mIflag = mIflag & ~d;
                default: ;
            endcase
        end
        mIflag = mIflag | ev;
        hist.push_front(pins);
        void'(hist.pop_back());
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, BASE, 8'h00, curPins);
    endtask

    task automatic writeReg(input logic [2:0] off, input logic [7:0] d);
        applyStimulus(1'b1, 1'b0, BASE + 8'(off), d, curPins);
    endtask

    task automatic readReg(input logic [2:0] off, output logic [7:0] v);
        applyStimulus(1'b0, 1'b1, BASE + 8'(off), 8'h00, curPins);
        v = bus.din;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        mOut = 8'h00; mTris = 8'hFF; mIe = 8'h00; mEdge = 8'h00; mIflag = 8'h00; mRd = 8'h00;
        hist = {};
        for (int k = 0; k <= S; k++) hist.push_back(8'h00);
        cyc = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        curPins = 8'hFF;
        port_in = 8'hFF;
        doReset();
        testsRun++;
        if (port_tris !== 8'hFF || port_out !== 8'h00 || irq !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got tris=%h out=%h irq=%b expected FF 00 0", port_tris, port_out, irq);
        end
        idle(10);
        readReg(3'd7, v);
        testsRun++;
        if (v !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_iflag: got %h expected 00", v); end
        testsRun++;
        if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        readReg(3'd2, v);
        testsRun++;
        if (v !== 8'hFF) begin testsFailed++; $display("[TB] FAIL reset_in: got %h expected FF", v); end
    endtask

    task automatic test_out_set_clr();
        logic [7:0] v;
        writeReg(3'd0, 8'h0F);
        writeReg(3'd3, 8'h30);
        writeReg(3'd4, 8'h01);
        readReg(3'd0, v);
        testsRun++;
        if (v !== 8'h3E) begin testsFailed++; $display("[TB] FAIL out_read: got %h expected 3E", v); end
        testsRun++;
        if (port_out !== 8'h3E) begin testsFailed++; $display("[TB] FAIL port_out: got %h expected 3E", port_out); end
    endtask

    task automatic test_rise_irq();
        curPins = 8'h00;
        idle(S + 3);
        writeReg(3'd6, 8'h00);
        writeReg(3'd5, 8'h01);
        writeReg(3'd7, 8'hFF);
        curPins = 8'h01;
        for (int k = 0; k < S; k++) begin
            idle(1);
            testsRun++;
            if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL rise_early_irq: cycle %0d got %b expected 0", k, irq); end
        end
        idle(1);
        testsRun++;
        if (irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL rise_irq: got %b expected 1", irq); end
        writeReg(3'd7, 8'h01);
        testsRun++;
        if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL w1c_irq: got %b expected 0", irq); end
    endtask

    task automatic test_w1c_collision();
        logic [7:0] v;
        curPins = 8'h00;
        idle(S + 2);
        curPins = 8'h01;
        idle(S);
        writeReg(3'd7, 8'h01);
        readReg(3'd7, v);
        testsRun++;
        if (v !== 8'h01) begin testsFailed++; $display("[TB] FAIL collision_iflag: got %h expected 01", v); end
        testsRun++;
        if (irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL collision_irq: got %b expected 1", irq); end
    endtask

    task automatic test_fall_edge();
        logic [7:0] v;
        curPins = 8'h09;
        idle(S + 3);
        writeReg(3'd6, 8'h08);
        writeReg(3'd5, 8'h08);
        writeReg(3'd7, 8'hFF);
        curPins = 8'h01;
        idle(S + 2);
        readReg(3'd7, v);
        testsRun++;
        if (v !== 8'h08) begin testsFailed++; $display("[TB] FAIL fall_iflag: got %h expected 08", v); end
        testsRun++;
        if (irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL fall_irq: got %b expected 1", irq); end
        writeReg(3'd7, 8'h08);
        curPins = 8'h09;
        idle(S + 3);
        readReg(3'd7, v);
        testsRun++;
        if (v !== 8'h00) begin testsFailed++; $display("[TB] FAIL fall_no_rise: got %h expected 00", v); end
    endtask

    task automatic test_tris_and_window();
        logic [7:0] v;
        writeReg(3'd1, 8'hFB);
        writeReg(3'd6, 8'h00);
        writeReg(3'd5, 8'h04);
        writeReg(3'd7, 8'hFF);
        for (int k = 0; k < 4; k++) begin
            curPins = curPins ^ 8'h04;
            idle(S + 2);
        end
        readReg(3'd7, v);
        testsRun++;
        if (v !== 8'h00) begin testsFailed++; $display("[TB] FAIL tris_masked: got %h expected 00", v); end
        writeReg(3'd1, 8'hFF);
        readReg(3'd0, v);
        applyStimulus(1'b0, 1'b1, BASE + 8'd8, 8'h00, curPins);
        v = bus.din;
        // A 2-state simulator may resolve an undriven bus to 0; rd_data here is nonzero either way.
        testsRun++;
        if (!(v === 8'hzz || v === 8'h00)) begin testsFailed++; $display("[TB] FAIL outside_din: got %h expected zz", v); end
        applyStimulus(1'b0, 1'b0, BASE, 8'h00, curPins);
        testsRun++;
        if (bus.din !== 8'h3E) begin testsFailed++; $display("[TB] FAIL outside_no_capture: got %h expected 3E", bus.din); end
    endtask

    task automatic test_same_cycle_rw();
        logic [7:0] v;
        readReg(3'd5, v);
        applyStimulus(1'b1, 1'b1, BASE, 8'h5A, curPins);
        testsRun++;
        if (bus.din !== 8'h04) begin testsFailed++; $display("[TB] FAIL rw_din_held: got %h expected 04", bus.din); end
        testsRun++;
        if (port_out !== 8'h5A) begin testsFailed++; $display("[TB] FAIL rw_write: got %h expected 5A", port_out); end
    endtask

    task automatic test_ie_mask();
        logic [7:0] v;
        writeReg(3'd6, 8'h00);
        writeReg(3'd5, 8'h01);
        writeReg(3'd7, 8'hFF);
        curPins = curPins & 8'hFE;
        idle(S + 2);
        curPins = curPins | 8'h01;
        idle(S + 2);
        testsRun++;
        if (irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL mask_pre_irq: got %b expected 1", irq); end
        writeReg(3'd5, 8'h00);
        testsRun++;
        if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL mask_irq: got %b expected 0", irq); end
        readReg(3'd7, v);
        testsRun++;
        if (v[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL mask_retain: got %h expected bit0 set", v); end
    endtask

    task automatic test_async_reset();
        writeReg(3'd0, 8'hA5);
        writeReg(3'd1, 8'h0F);
        #2 reset_n = 1'b0;
        #1;
        testsRun++;
        if (port_out !== 8'h00 || port_tris !== 8'hFF || irq !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: got out=%h tris=%h irq=%b expected 00 FF 0", port_out, port_tris, irq);
        end
        doReset();
    endtask

    task automatic test_random();
        logic [7:0] a, d, p;
        logic       wr, rd;
        int         op;
        p = curPins;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) p = p ^ 8'(1 << $urandom_range(0, 7));
            op = $urandom_range(0, 3);
            wr = (op == 1 || op == 3);
            rd = (op == 2 || op == 3);
            a  = ($urandom_range(0, 9) == 0) ? 8'(8'h78 + $urandom_range(0, 23)) : 8'(BASE + $urandom_range(0, 7));
            d  = 8'($urandom);
            applyStimulus(wr, rd, a, d, p);
            testsRun++;
            if (port_out !== mOut || port_tris !== mTris || irq !== |(mIflag & mIe)) begin
                testsFailed++;
                $display("[TB] FAIL rand_outputs: n=%0d got out=%h tris=%h irq=%b expected %h %h %b",
                         n, port_out, port_tris, irq, mOut, mTris, |(mIflag & mIe));
            end
            if (8'(a - BASE) < 8) begin
                testsRun++;
                if (bus.din !== mRd) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_din: n=%0d addr=%h got %h expected %h", n, a, bus.din, mRd);
                end
            end
        end
    endtask

    initial begin
        reset_n   = 1'b1;
        bus.addr  = 8'h00;
        bus.dout  = 8'h00;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        port_in   = 8'h00;
        curPins   = 8'h00;
        test_reset();
        test_out_set_clr();
        test_rise_irq();
        test_w1c_collision();
        test_fall_edge();
        test_tris_and_window();
        test_same_cycle_rw();
        test_ie_mask();
        test_async_reset();
        writeReg(3'd5, 8'hFF);
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
